// File: rtl/id_stage_if.sv
// ID stage bus: fetch inputs, hazard and writeback inputs, decode outputs.
// master drives fetch/EX/WB side, slave is the decode stage.
interface id_stage_if;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        fetch_valid;
  logic        flush;
  logic        ex_mem_rd;
  logic [4:0]  ex_rd;
  logic        wb_reg_wr;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        stall;
  logic [31:0] pc_out;
  logic [31:0] imm;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] val_a;
  logic [31:0] val_b;
  logic        alu_src_imm;
  logic        res_sel_pc;
  logic        mem_rd;
  logic        mem_wr;
  logic        reg_wr;
  logic        wb_sel_mem;
  logic        illegal;

  modport master (
    output instr_in, pc_in, fetch_valid, flush,
    output ex_mem_rd, ex_rd,
    output wb_reg_wr, wb_rd, wb_data,
    input  stall, pc_out, imm,
    input  rs1, rs2, rd, funct7, funct3,
    input  val_a, val_b,
    input  alu_src_imm, res_sel_pc,
    input  mem_rd, mem_wr, reg_wr,
    input  wb_sel_mem, illegal
  );

  modport slave (
    input  instr_in, pc_in, fetch_valid, flush,
    input  ex_mem_rd, ex_rd,
    input  wb_reg_wr, wb_rd, wb_data,
    output stall, pc_out, imm,
    output rs1, rs2, rd, funct7, funct3,
    output val_a, val_b,
    output alu_src_imm, res_sel_pc,
    output mem_rd, mem_wr, reg_wr,
    output wb_sel_mem, illegal
  );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID latch, register file,
// immediate/control decode and load-use stall.
module id_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter logic [31:0] REG_INIT  = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst,
  id_stage_if.slave  bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] rf_q [32];

  logic [6:0]  opc;
  logic [4:0]  rs1_f, rs2_f;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] imm_d;
  logic        known, use1, use2;
  logic        c_reg_wr, c_alu_imm, c_pc4;
  logic        c_mem_rd, c_mem_wr, c_wb_mem;
  logic        stall_w, bubble;
  logic [31:0] val_a_d, val_b_d;

  assign opc   = instr_q[6:0];
  assign rs1_f = instr_q[19:15];
  assign rs2_f = instr_q[24:20];

  // Latch next state: flush beats stall beats a fresh load.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (bus.flush) begin
      instr_d = NOP_INSTR;
      pc_d    = bus.pc_in;
      valid_d = 1'b0;
    end else if (!stall_w) begin
      instr_d = bus.instr_in;
      pc_d    = bus.pc_in;
      valid_d = bus.fetch_valid;
    end
  end

  // IF/ID latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  // Register file write port, x0 never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++)
        rf_q[i] <= (i == 0) ? '0 : REG_INIT;
    end else if (bus.wb_reg_wr && bus.wb_rd != 5'd0) begin
      rf_q[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Read ports with write-first bypass from WB.
  always_comb begin
    val_a_d = rf_q[rs1_f];
    val_b_d = rf_q[rs2_f];
    if (rs1_f == 5'd0)
      val_a_d = '0;
    else if (bus.wb_reg_wr && bus.wb_rd == rs1_f)
      val_a_d = bus.wb_data;
    if (rs2_f == 5'd0)
      val_b_d = '0;
    else if (bus.wb_reg_wr && bus.wb_rd == rs2_f)
      val_b_d = bus.wb_data;
  end

  assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s = {{20{instr_q[31]}}, instr_q[31:25],
                  instr_q[11:7]};
  assign imm_b = {{19{instr_q[31]}}, instr_q[31],
                  instr_q[7], instr_q[30:25],
                  instr_q[11:8], 1'b0};
  assign imm_u = {instr_q[31:12], 12'b0};
  assign imm_j = {{11{instr_q[31]}}, instr_q[31],
                  instr_q[19:12], instr_q[20],
                  instr_q[30:21], 1'b0};

  // Opcode decode: raw controls, immediate and operand usage.
  always_comb begin
    known     = 1'b1;
    use1      = 1'b0;
    use2      = 1'b0;
    imm_d     = '0;
    c_reg_wr  = 1'b0;
    c_alu_imm = 1'b0;
    c_pc4     = 1'b0;
    c_mem_rd  = 1'b0;
    c_mem_wr  = 1'b0;
    c_wb_mem  = 1'b0;
    unique case (opc)
      OPC_OP: begin
        c_reg_wr = 1'b1;
        use1     = 1'b1;
        use2     = 1'b1;
      end
      OPC_OPIMM: begin
        c_reg_wr  = 1'b1;
        c_alu_imm = 1'b1;
        use1      = 1'b1;
        imm_d     = imm_i;
      end
      OPC_LOAD: begin
        c_reg_wr  = 1'b1;
        c_alu_imm = 1'b1;
        c_mem_rd  = 1'b1;
        c_wb_mem  = 1'b1;
        use1      = 1'b1;
        imm_d     = imm_i;
      end
      OPC_STORE: begin
        c_mem_wr  = 1'b1;
        c_alu_imm = 1'b1;
        use1      = 1'b1;
        use2      = 1'b1;
        imm_d     = imm_s;
      end
      OPC_BRANCH: begin
        use1  = 1'b1;
        use2  = 1'b1;
        imm_d = imm_b;
      end
      OPC_JAL: begin
        c_reg_wr = 1'b1;
        c_pc4    = 1'b1;
        imm_d    = imm_j;
      end
      OPC_JALR: begin
        c_reg_wr  = 1'b1;
        c_pc4     = 1'b1;
        c_alu_imm = 1'b1;
        use1      = 1'b1;
        imm_d     = imm_i;
      end
      OPC_LUI, OPC_AUIPC: begin
        c_reg_wr  = 1'b1;
        c_alu_imm = 1'b1;
        imm_d     = imm_u;
      end
      default: known = 1'b0;
    endcase
  end

  // A load in EX whose rd feeds this instruction costs one bubble.
  assign stall_w = valid_q && bus.ex_mem_rd &&
                   (bus.ex_rd != 5'd0) &&
                   ((use1 && rs1_f == bus.ex_rd) ||
                    (use2 && rs2_f == bus.ex_rd)) &&
                   !bus.flush;
  assign bubble  = stall_w || !valid_q;

  assign bus.stall       = stall_w;
  assign bus.pc_out      = pc_q;
  assign bus.imm         = imm_d;
  assign bus.rs1         = rs1_f;
  assign bus.rs2         = rs2_f;
  assign bus.rd          = instr_q[11:7];
  assign bus.funct7      = instr_q[31:25];
  assign bus.funct3      = instr_q[14:12];
  assign bus.val_a       = val_a_d;
  assign bus.val_b       = val_b_d;
  assign bus.reg_wr      = c_reg_wr  && !bubble;
  assign bus.alu_src_imm = c_alu_imm && !bubble;
  assign bus.res_sel_pc  = c_pc4     && !bubble;
  assign bus.mem_rd      = c_mem_rd  && !bubble;
  assign bus.mem_wr      = c_mem_wr  && !bubble;
  assign bus.wb_sel_mem  = c_wb_mem  && !bubble;
  assign bus.illegal     = !known    && !bubble;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed literal checks plus random
// stimulus compared each cycle against a behavioural model.
module tb_id_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_if bus ();
  id_stage dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_instr, m_pc;
  logic        m_valid;
  logic [31:0] m_rf [32];

  logic        e_stall;
  logic [6:0]  e_ctl;
  logic [31:0] e_imm, e_va, e_vb;

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic mreset();
    m_instr = 32'h13;
    m_pc    = 0;
    m_valid = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
  endtask

  // Per-opcode table: known, uses rs1, uses rs2, imm kind,
  // controls {reg_wr,alu_imm,mem_rd,wb_mem,mem_wr,pc4}.
  task automatic info(input logic [6:0] op,
                      output bit kn, output bit u1,
                      output bit u2, output int ik,
                      output logic [5:0] c);
    kn = 1; u1 = 0; u2 = 0; ik = 0; c = 0;
    case (op)
      7'h33: begin u1 = 1; u2 = 1; c = 6'b100000; end
      7'h13: begin u1 = 1; ik = 1; c = 6'b110000; end
      7'h03: begin u1 = 1; ik = 1; c = 6'b111100; end
      7'h23: begin u1 = 1; u2 = 1; ik = 2;
                   c = 6'b010010; end
      7'h63: begin u1 = 1; u2 = 1; ik = 3; end
      7'h6F: begin ik = 5; c = 6'b100001; end
      7'h67: begin u1 = 1; ik = 1; c = 6'b110001; end
      7'h37, 7'h17: begin ik = 4; c = 6'b110000; end
      default: kn = 0;
    endcase
  endtask

  function automatic logic [31:0] rdreg(input logic [4:0] r);
    if (r == 0) return 0;
    if (bus.wb_reg_wr && bus.wb_rd == r) return bus.wb_data;
    return m_rf[r];
  endfunction

  task automatic model_eval();
    bit kn, u1, u2;
    int ik;
    logic [5:0] c;
    logic [31:0] x, si;
    logic [4:0] r1, r2;
    x  = m_instr;
    r1 = x[19:15];
    r2 = x[24:20];
    si = 32'($signed(x) >>> 20);
    info(x[6:0], kn, u1, u2, ik, c);
    case (ik)
      1: e_imm = si;
      2: e_imm = {si[31:5], x[11:7]};
      3: e_imm = {si[31:12], x[7], x[30:25], x[11:8], 1'b0};
      4: e_imm = {x[31:12], 12'h000};
      5: e_imm = {si[31:20], x[19:12], x[20], x[30:21], 1'b0};
      default: e_imm = 0;
    endcase
    e_stall = m_valid && bus.ex_mem_rd && bus.ex_rd != 0 &&
              ((u1 && r1 == bus.ex_rd) ||
               (u2 && r2 == bus.ex_rd)) && !bus.flush;
    if (e_stall || !m_valid) e_ctl = 0;
    else e_ctl = {c, !kn};
    e_va = rdreg(r1);
    e_vb = rdreg(r2);
  endtask

  task automatic half();
    logic [31:0] f;
    @(negedge clk);
    model_eval();
    chk("stall", {31'b0, bus.stall}, {31'b0, e_stall});
    chk("ctl", {25'b0, bus.reg_wr, bus.alu_src_imm,
                bus.mem_rd, bus.wb_sel_mem, bus.mem_wr,
                bus.res_sel_pc, bus.illegal}, {25'b0, e_ctl});
    chk("imm", bus.imm, e_imm);
    chk("pc_out", bus.pc_out, m_pc);
    f = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, 7'b0};
    chk("fields", f, {m_instr[31:7], 7'b0});
    chk("val_a", bus.val_a, e_va);
    chk("val_b", bus.val_b, e_vb);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) mreset();
    else begin
      model_eval();
      if (bus.wb_reg_wr && bus.wb_rd != 0)
        m_rf[bus.wb_rd] = bus.wb_data;
      if (bus.flush) begin
        m_instr = 32'h13; m_pc = bus.pc_in; m_valid = 0;
      end else if (!e_stall) begin
        m_instr = bus.instr_in; m_pc = bus.pc_in;
        m_valid = bus.fetch_valid;
      end
    end
    #1;
  endtask

  task automatic clr();
    bus.instr_in = 0; bus.pc_in = 0; bus.fetch_valid = 0;
    bus.flush = 0; bus.ex_mem_rd = 0; bus.ex_rd = 0;
    bus.wb_reg_wr = 0; bus.wb_rd = 0; bus.wb_data = 0;
  endtask

  task automatic load(input logic [31:0] ins,
                      input logic [31:0] pc);
    clr();
    bus.instr_in = ins; bus.pc_in = pc; bus.fetch_valid = 1;
    half();
    tick();
    clr();
  endtask

  logic [6:0] pool [10] = '{7'h33, 7'h13, 7'h03, 7'h23,
    7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};

  initial begin
    logic [31:0] r;
    clr();
    rst = 1;
    mreset();
    repeat (2) @(negedge clk);
    half();
    chk("rst_stall", {31'b0, bus.stall}, 0);
    chk("rst_imm", bus.imm, 0);
    chk("rst_rd", {27'b0, bus.rd}, 0);
    chk("rst_reg_wr", {31'b0, bus.reg_wr}, 0);
    rst = 0;
    tick();

    load(32'h00500093, 32'h4);
    half();
    chk("t1_rd", {27'b0, bus.rd}, 1);
    chk("t1_rs1", {27'b0, bus.rs1}, 0);
    chk("t1_imm", bus.imm, 5);
    chk("t1_reg_wr", {31'b0, bus.reg_wr}, 1);
    chk("t1_alu_imm", {31'b0, bus.alu_src_imm}, 1);
    chk("t1_val_a", bus.val_a, 0);
    chk("t1_stall", {31'b0, bus.stall}, 0);
    tick();

    load(32'h002101B3, 32'h8);
    bus.wb_reg_wr = 1; bus.wb_rd = 2;
    bus.wb_data = 32'hDEADBEEF;
    half();
    chk("t2_byp_a", bus.val_a, 32'hDEADBEEF);
    chk("t2_byp_b", bus.val_b, 32'hDEADBEEF);
    tick();
    load(32'h00000033, 32'hC);
    bus.wb_reg_wr = 1; bus.wb_rd = 0; bus.wb_data = 32'h1234;
    half();
    chk("t2_x0_a", bus.val_a, 0);
    chk("t2_x0_b", bus.val_b, 0);
    tick();

    load(32'h00208233, 32'h40);
    bus.instr_in = 32'h13; bus.pc_in = 32'h44;
    bus.fetch_valid = 1;
    bus.ex_mem_rd = 1; bus.ex_rd = 2;
    half();
    chk("t3_stall", {31'b0, bus.stall}, 1);
    chk("t3_bubble", {31'b0, bus.reg_wr}, 0);
    chk("t3_val_b", bus.val_b, 32'hDEADBEEF);
    tick();
    bus.ex_mem_rd = 0;
    half();
    chk("t3_held_rd", {27'b0, bus.rd}, 4);
    chk("t3_held_pc", bus.pc_out, 32'h40);
    chk("t3_reg_wr", {31'b0, bus.reg_wr}, 1);
    bus.ex_mem_rd = 1; bus.ex_rd = 0;
    #1;
    chk("t3_x0_nostall", {31'b0, bus.stall}, 0);
    tick();

    load(32'h123452B7, 32'h48);
    bus.ex_mem_rd = 1; bus.ex_rd = 0;
    half();
    chk("t4_imm", bus.imm, 32'h12345000);
    chk("t4_stall0", {31'b0, bus.stall}, 0);
    bus.ex_rd = 5;
    #1;
    chk("t4_stall5", {31'b0, bus.stall}, 0);
    tick();

    load(32'h00208233, 32'h50);
    bus.ex_mem_rd = 1; bus.ex_rd = 2; bus.flush = 1;
    bus.instr_in = 32'h00500093; bus.fetch_valid = 1;
    bus.pc_in = 32'h200;
    half();
    chk("t5_flush_stall", {31'b0, bus.stall}, 0);
    tick();
    half();
    chk("t5_reg_wr", {31'b0, bus.reg_wr}, 0);
    chk("t5_rd", {27'b0, bus.rd}, 0);
    chk("t5_pc", bus.pc_out, 32'h200);
    tick();

    load(32'hFE000EE3, 32'h60);
    half();
    chk("t6_b_imm", bus.imm, 32'hFFFFFFFC);
    chk("t6_b_ctl", {31'b0, bus.reg_wr | bus.alu_src_imm}, 0);
    tick();
    load(32'hFFDFF0EF, 32'h64);
    half();
    chk("t6_j_imm", bus.imm, 32'hFFFFFFFC);
    chk("t6_j_pc4", {30'b0, bus.reg_wr, bus.res_sel_pc}, 3);
    tick();
    load(32'h0000007F, 32'h68);
    half();
    chk("t6_illegal", {31'b0, bus.illegal}, 1);
    tick();

    load(32'h00208233, 32'h70);
    bus.ex_mem_rd = 1; bus.ex_rd = 1;
    half();
    chk("t7_stall", {31'b0, bus.stall}, 1);
    rst = 1;
    #1;
    chk("t7_rst_stall", {31'b0, bus.stall}, 0);
    chk("t7_rst_rd", {27'b0, bus.rd}, 0);
    mreset();
    #2;
    rst = 0;
    tick();

    for (int n = 0; n < 3000; n++) begin
      r = $urandom;
      bus.instr_in = r;
      bus.instr_in[6:0] = pool[$urandom_range(0, 9)];
      if ($urandom_range(0, 1) == 1) begin
        bus.instr_in[19:15] = 5'($urandom_range(0, 7));
        bus.instr_in[24:20] = 5'($urandom_range(0, 7));
      end
      bus.pc_in = $urandom;
      bus.fetch_valid = ($urandom_range(0, 9) < 8);
      bus.flush = ($urandom_range(0, 9) == 0);
      bus.ex_mem_rd = ($urandom_range(0, 9) < 4);
      bus.ex_rd = 5'($urandom_range(0, 7));
      bus.wb_reg_wr = ($urandom_range(0, 1) == 1);
      bus.wb_rd = 5'($urandom_range(0, 7));
      bus.wb_data = $urandom;
      half();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
